soc_system_pio_in_multi: RTL and testbench

- Multi-channel Avalon-MM input PIO; next generation of the single-channel 16-bit input ports (x_min style) in soc_system.
- Samples NUM_CH external buses of DATA_W bits each through a synchroniser.
- Provides continuous or atomic-snapshot read-back of all channels, per-channel change capture, and a maskable interrupt to the HPS.

---
 rtl/soc_system_pio_pkg.sv | 18 +
 rtl/soc_system_pio_sync.sv | 26 ++
 rtl/soc_system_pio_in_multi.sv | 91 +++++++++
 tb/tb_soc_system_pio_in_multi.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/soc_system_pio_pkg.sv
// Shared register map and control-bit definitions for the multi-channel input PIO.
package soc_system_pio_pkg;

  // Fixed-address registers; addresses below these select channel snapshots or read 0.
  typedef enum logic [3:0] {
    ADDR_CAPTURE = 4'd12,
    ADDR_MASK    = 4'd13,
    ADDR_CTRL    = 4'd14,
    ADDR_INFO    = 4'd15
  } reg_addr_e;

  // CTRL register bit positions.
  localparam int unsigned CTRL_SNAP = 0;
  localparam int unsigned CTRL_AUTO = 1;

  localparam logic [7:0] VERSION = 8'h01;

endpackage

// File: rtl/soc_system_pio_sync.sv
// Multi-stage synchroniser for a bus of asynchronous inputs.
module soc_system_pio_sync #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [STAGES];

  // Shift the input through the flop chain; reset clears every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= d;
      for (int unsigned i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[STAGES-1];

endmodule

// File: rtl/soc_system_pio_in_multi.sv
// Multi-channel Avalon-MM input PIO with snapshot, change capture and maskable irq.
module soc_system_pio_in_multi
  import soc_system_pio_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               address,
  input  logic                     write,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  output logic                     irq
);

  logic [NUM_CH*DATA_W-1:0] sync_bus;
  logic [NUM_CH*DATA_W-1:0] prev_bus;
  logic [NUM_CH*DATA_W-1:0] snap_bus;
  logic [NUM_CH-1:0]        chg;
  logic [NUM_CH-1:0]        clr;
  logic [NUM_CH-1:0]        capture;
  logic [NUM_CH-1:0]        mask;
  logic                     auto_mode;
  logic                     wr_capture;
  logic                     wr_mask;
  logic                     wr_ctrl;
  logic                     snap_load;
  logic [31:0]              rd_next;
  logic                     unused_wdata;

  soc_system_pio_sync #(
    .WIDTH  (NUM_CH*DATA_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (sync_bus)
  );

  assign wr_capture   = write && (address == ADDR_CAPTURE);
  assign wr_mask      = write && (address == ADDR_MASK);
  assign wr_ctrl      = write && (address == ADDR_CTRL);
  assign clr          = wr_capture ? writedata[NUM_CH-1:0] : '0;
  // The strobe loads under the pre-write mode, so auto=0 plus strobe still snapshots.
  assign snap_load    = auto_mode || (wr_ctrl && writedata[CTRL_SNAP]);
  assign unused_wdata = ^writedata;

  // Per-channel change flag: any bit differing from the previous synchronised sample.
  always_comb begin
    chg = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      chg[i] = (sync_bus[i*DATA_W +: DATA_W] != prev_bus[i*DATA_W +: DATA_W]);
  end

  // Read mux; reflects register state before any same-cycle write.
  always_comb begin
    rd_next = '0;
    for (int unsigned i = 0; i < NUM_CH; i++)
      if (address == 4'(i)) rd_next = 32'(snap_bus[i*DATA_W +: DATA_W]);
    if (address == ADDR_CAPTURE) rd_next = 32'(capture);
    if (address == ADDR_MASK)    rd_next = 32'(mask);
    if (address == ADDR_CTRL)    rd_next = {30'd0, auto_mode, 1'b0};
    if (address == ADDR_INFO)    rd_next = {VERSION, 8'(SYNC_STAGES), 8'(NUM_CH), 8'(DATA_W)};
  end

  // Register state: history, snapshot, capture (set beats clear), mask, mode, irq, read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_bus  <= '0;
      snap_bus  <= '0;
      capture   <= '0;
      mask      <= '0;
      auto_mode <= 1'b1;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      prev_bus <= sync_bus;
      if (snap_load) snap_bus <= sync_bus;
      capture  <= (capture & ~clr) | chg;
      if (wr_mask) mask <= writedata[NUM_CH-1:0];
      if (wr_ctrl) auto_mode <= writedata[CTRL_AUTO];
      irq      <= |(capture & mask);
      readdata <= rd_next;
    end
  end

endmodule

// File: tb/tb_soc_system_pio_in_multi.sv
// Directed self-checking bench for soc_system_pio_in_multi (default parameters).
module tb_soc_system_pio_in_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [63:0] in_port;
  logic        irq;
  logic [31:0] v;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  soc_system_pio_in_multi #(
    .DATA_W      (16),
    .NUM_CH      (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .write     (write),
    .writedata (writedata),
    .readdata  (readdata),
    .in_port   (in_port),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one clock, returning at the following falling edge.
  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick(1);
    write     = 1'b0;
    writedata = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    d = readdata;
  endtask

  task automatic set_ch(input int unsigned c, input logic [15:0] val);
    in_port[c*16 +: 16] = val;
  endtask

  initial begin
    reset     = 1'b1;
    address   = 4'd15;
    write     = 1'b0;
    writedata = '0;
    in_port   = 64'hAAAA_5555_AAAA_5555;
    @(negedge clk);
    tick(3);
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'd0, irq}, 32'h0);
    tick(1);
    check("reset_readdata_hold", readdata, 32'h0);
    reset = 1'b0;

    rd(4'd15, v);
    check("info", v, 32'h0102_0410);

    // Quiesce inputs and clear the capture raised by the nonzero reset inputs.
    in_port = '0;
    tick(6);
    wr(4'd12, 32'hF);
    rd(4'd12, v);
    check("capture_cleared", v, 32'h0);

    // Auto-mode latency: visible on the fourth edge after the input changes.
    address = 4'd2;
    set_ch(2, 16'hBEEF);
    tick(3);
    check("latency_t3", readdata, 32'h0);
    tick(1);
    check("latency_t4", readdata, 32'h0000_BEEF);

    // Atomic snapshot.
    wr(4'd14, 32'h0);
    set_ch(0, 16'h1234);
    set_ch(1, 16'h5678);
    tick(5);
    rd(4'd0, v);
    check("frozen_ch0_old", v, 32'h0);
    rd(4'd1, v);
    check("frozen_ch1_old", v, 32'h0);
    wr(4'd14, 32'h1);
    rd(4'd0, v);
    check("snap_ch0", v, 32'h0000_1234);
    rd(4'd1, v);
    check("snap_ch1", v, 32'h0000_5678);
    rd(4'd14, v);
    check("ctrl_auto_off", v, 32'h0);
    set_ch(0, 16'h1111);
    set_ch(1, 16'h2222);
    tick(5);
    rd(4'd0, v);
    check("snap_hold_ch0", v, 32'h0000_1234);
    rd(4'd1, v);
    check("snap_hold_ch1", v, 32'h0000_5678);
    wr(4'd12, 32'hF);

    // Capture and irq on an enabled channel.
    wr(4'd13, 32'h2);
    rd(4'd13, v);
    check("mask_readback", v, 32'h2);
    set_ch(1, 16'h2202);
    tick(5);
    rd(4'd12, v);
    check("capture_ch1", v, 32'h2);
    check("irq_set", {31'd0, irq}, 32'h1);
    wr(4'd12, 32'h2);
    check("irq_after_w1c_1", {31'd0, irq}, 32'h1);
    tick(1);
    check("irq_after_w1c_2", {31'd0, irq}, 32'h0);
    rd(4'd12, v);
    check("capture_w1c", v, 32'h0);

    // Masked channel captures without raising irq.
    set_ch(3, 16'h0001);
    tick(5);
    rd(4'd12, v);
    check("capture_ch3_masked", v, 32'h8);
    check("irq_masked", {31'd0, irq}, 32'h0);
    wr(4'd12, 32'h8);

    // Set wins over a simultaneous clear on ch0.
    set_ch(0, 16'h1110);
    tick(5);
    set_ch(0, 16'h1111);
    tick(2);
    wr(4'd12, 32'h1);
    rd(4'd12, v);
    check("set_beats_clear", v, 32'h1);

    // Writes to channel and reserved addresses are ignored.
    wr(4'd0, 32'hFFFF_FFFF);
    rd(4'd0, v);
    check("snap_write_ignored", v, 32'h0000_1234);
    rd(4'd7, v);
    check("reserved_reads_0", v, 32'h0);

    // Reset mid-operation with auto off and an irq pending.
    wr(4'd13, 32'hF);
    tick(2);
    check("irq_before_reset", {31'd0, irq}, 32'h1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("irq_after_reset", {31'd0, irq}, 32'h0);
    rd(4'd0, v);
    check("snap_after_reset", v, 32'h0);
    rd(4'd14, v);
    check("ctrl_after_reset", v, 32'h2);
    rd(4'd12, v);
    check("capture_after_reset", v, 32'h0);
    rd(4'd13, v);
    check("mask_after_reset", v, 32'h0);
    tick(4);
    rd(4'd12, v);
    check("capture_nonzero_first", v, 32'hF);
    check("irq_mask0", {31'd0, irq}, 32'h0);
    rd(4'd2, v);
    check("auto_ch2_after_reset", v, 32'h0000_BEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
